// File: rtl/coax_tx.sv
// Manchester-coded coax frame transmitter: quiesce preamble, code violation, then
// sync/data/parity per word (chained back to back while words keep arriving), then end sequence.
module coax_tx #(
    parameter int CLOCKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] data,
    input  logic       strobe,
    output logic       ready,
    output logic       active,
    output logic       tx
);

    localparam int CW = $clog2(3 * CLOCKS_PER_BIT);
    localparam logic [CW-1:0] HALF      = CW'(CLOCKS_PER_BIT / 2);
    localparam logic [CW-1:0] CELL_LAST = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] CV_HALF   = CW'(3 * CLOCKS_PER_BIT / 2);
    localparam logic [CW-1:0] CV_LAST   = CW'(3 * CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] ES2_LAST  = CW'(2 * CLOCKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LINE_QUIESCE,
        CODE_VIOLATION,
        SYNC_BIT,
        DATA_BIT,
        PARITY_BIT,
        END_SEQUENCE_1,
        END_SEQUENCE_2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [9:0]    shift_q, shift_d;
    logic [9:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          ready_q, active_q, tx_q;
    logic          accept;
    logic          cell_end;

    // Line level for a given position; Manchester bit b is !b in the first half, b in the second.
    function automatic logic line_level(state_t st, logic [3:0] bit_idx,
                                        logic [CW-1:0] cyc, logic [9:0] word);
        logic second_half;
        logic lvl;
        second_half = (cyc >= HALF);
        lvl = 1'b0;
        case (st)
            LINE_QUIESCE, SYNC_BIT: lvl = second_half;
            CODE_VIOLATION:         lvl = (cyc >= CV_HALF);
            DATA_BIT:               lvl = word[4'd9 - bit_idx] ~^ second_half;
            PARITY_BIT:             lvl = (~^word) ~^ second_half;
            END_SEQUENCE_1:         lvl = !second_half;
            END_SEQUENCE_2:         lvl = 1'b1;
            default:                lvl = 1'b0;
        endcase
        return lvl;
    endfunction

    assign accept   = strobe && ready_q;
    assign cell_end = (cyc_q == CELL_LAST);

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        cyc_d       = cyc_q + 1'b1;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        if (accept) begin
            hold_d      = data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                cyc_d = '0;
                bit_d = '0;
                if (hold_full_q || accept) state_d = LINE_QUIESCE;
            end
            LINE_QUIESCE: if (cell_end) begin
                cyc_d = '0;
                if (bit_q == 4'd4) begin
                    bit_d   = '0;
                    state_d = CODE_VIOLATION;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            CODE_VIOLATION: if (cyc_q == CV_LAST) begin
                cyc_d       = '0;
                state_d     = SYNC_BIT;
                shift_d     = hold_q;
                hold_full_d = 1'b0;
            end
            SYNC_BIT: if (cell_end) begin
                cyc_d   = '0;
                bit_d   = '0;
                state_d = DATA_BIT;
            end
            DATA_BIT: if (cell_end) begin
                cyc_d = '0;
                if (bit_q == 4'd9) begin
                    bit_d   = '0;
                    state_d = PARITY_BIT;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            PARITY_BIT: if (cell_end) begin
                cyc_d = '0;
                // A word already waiting chains straight into the next sync cell.
                if (hold_full_q) begin
                    state_d     = SYNC_BIT;
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                end else begin
                    state_d = END_SEQUENCE_1;
                end
            end
            END_SEQUENCE_1: if (cell_end) begin
                cyc_d   = '0;
                state_d = END_SEQUENCE_2;
            end
            END_SEQUENCE_2: if (cyc_q == ES2_LAST) begin
                cyc_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cyc_d   = '0;
                bit_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_q       <= '0;
            cyc_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
            active_q    <= 1'b0;
            tx_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            cyc_q       <= cyc_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ready_q     <= !hold_full_d;
            active_q    <= (state_d != IDLE);
            tx_q        <= line_level(state_d, bit_d, cyc_d, shift_d);
        end
    end

    assign ready  = ready_q;
    assign active = active_q;
    assign tx     = tx_q;

endmodule

// File: tb/tb_coax_tx.sv
// Directed bench for coax_tx at CLOCKS_PER_BIT=8: frames are recorded cycle by cycle
// and compared against waveforms built from the line-code rules.
module tb_coax_tx;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] data;
    logic       strobe;
    logic       ready;
    logic       active;
    logic       tx;

    int checks = 0;
    int errors = 0;

    bit exp_q[$];
    bit got_tx[$];
    bit got_rdy[$];
    logic post_tx;
    logic post_active;

    coax_tx #(.CLOCKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .reset  (reset),
        .data   (data),
        .strobe (strobe),
        .ready  (ready),
        .active (active),
        .tx     (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cell(input bit b);
        for (int i = 0; i < CPB; i++) exp_q.push_back(i < CPB / 2 ? !b : b);
    endtask

    task automatic build_frame(input int nwords, input logic [9:0] w0, input logic [9:0] w1);
        logic [9:0] w;
        exp_q.delete();
        for (int i = 0; i < 5; i++) push_cell(1'b1);
        for (int i = 0; i < 3 * CPB / 2; i++) exp_q.push_back(1'b0);
        for (int i = 0; i < 3 * CPB / 2; i++) exp_q.push_back(1'b1);
        for (int k = 0; k < nwords; k++) begin
            w = (k == 0) ? w0 : w1;
            push_cell(1'b1);
            for (int b = 9; b >= 0; b--) push_cell(w[b]);
            push_cell(~^w);
        end
        push_cell(1'b0);
        for (int i = 0; i < 2 * CPB; i++) exp_q.push_back(1'b1);
    endtask

    task automatic strobe_word(input logic [9:0] w);
        strobe = 1'b1;
        data   = w;
        tick();
        strobe = 1'b0;
    endtask

    // Records tx/ready while active; optionally strobes inj_data right after sample inj_idx.
    task automatic capture(input int inj_idx, input logic [9:0] inj_data);
        int n;
        got_tx.delete();
        got_rdy.delete();
        n = 0;
        while (active === 1'b1 && n < 2000) begin
            got_tx.push_back(tx);
            got_rdy.push_back(ready);
            if (n == inj_idx) begin
                strobe = 1'b1;
                data   = inj_data;
            end
            tick();
            if (n == inj_idx) strobe = 1'b0;
            n++;
        end
        post_tx     = tx;
        post_active = active;
    endtask

    function automatic int first_diff();
        int lim;
        lim = (got_tx.size() < exp_q.size()) ? got_tx.size() : exp_q.size();
        for (int i = 0; i < lim; i++) if (got_tx[i] != exp_q[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1; strobe = 1'b0; data = '0;
        repeat (3) tick();
        checks++; if (tx !== 1'b0)     begin errors++; $display("FAIL reset_tx got %b exp 0", tx); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %b exp 0", active); end
        checks++; if (ready !== 1'b1)  begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
        strobe = 1'b1; data = 10'h155;
        tick();
        reset = 1'b0; strobe = 1'b0;
        checks++; if (ready !== 1'b1)  begin errors++; $display("FAIL reset_over_strobe_ready got %b exp 1", ready); end
        tick();
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_over_strobe_active got %b exp 0", active); end
        $display("reset: tx=%b active=%b ready=%b", tx, active, ready);
    endtask

    task automatic test_idle();
        int bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (tx !== 1'b0 || ready !== 1'b1 || active !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL idle_64 got %0d bad cycles exp 0", bad); end
        $display("idle: 64 cycles, bad=%0d", bad);
    endtask

    task automatic test_single();
        int d;
        strobe_word(10'b0110110011);
        checks++; if (active !== 1'b1 || tx !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("FAIL single_latency got a=%b tx=%b r=%b exp a=1 tx=0 r=0", active, tx, ready);
        end
        build_frame(1, 10'h1B3, 10'h000);
        capture(-1, '0);
        checks++; if (got_tx.size() != 184) begin errors++; $display("FAIL single_len got %0d exp 184", got_tx.size()); end
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL single_wave idx %0d got %b exp %b", d, got_tx[d], exp_q[d]); end
        checks++; if (got_rdy[63] !== 1'b0 || got_rdy[64] !== 1'b1) begin
            errors++; $display("FAIL single_ready_at_sync got %b%b exp 01", got_rdy[63], got_rdy[64]);
        end
        checks++; if (post_tx !== 1'b0 || post_active !== 1'b0) begin
            errors++; $display("FAIL single_end got tx=%b a=%b exp 0 0", post_tx, post_active);
        end
        $display("single: data=1b3 len=%0d", got_tx.size());
    endtask

    task automatic test_back_to_back();
        int d;
        strobe_word(10'h1B3);
        build_frame(2, 10'h1B3, 10'h2AA);
        capture(90, 10'h2AA);
        checks++; if (got_tx.size() != 280) begin errors++; $display("FAIL b2b_len got %0d exp 280", got_tx.size()); end
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL b2b_wave idx %0d got %b exp %b", d, got_tx[d], exp_q[d]); end
        checks++; if (got_rdy[91] !== 1'b0 || got_rdy[159] !== 1'b0 || got_rdy[160] !== 1'b1) begin
            errors++; $display("FAIL b2b_ready got %b%b%b exp 001", got_rdy[91], got_rdy[159], got_rdy[160]);
        end
        $display("back_to_back: data=1b3,2aa len=%0d", got_tx.size());
    endtask

    task automatic test_ignored();
        int d;
        int bad = 0;
        strobe_word(10'h0F0);
        build_frame(1, 10'h0F0, 10'h000);
        capture(10, 10'h155);
        checks++; if (got_tx.size() != 184) begin errors++; $display("FAIL ignored_len got %0d exp 184", got_tx.size()); end
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL ignored_wave idx %0d got %b exp %b", d, got_tx[d], exp_q[d]); end
        checks++; if (got_rdy[11] !== 1'b0 || got_rdy[63] !== 1'b0 || got_rdy[64] !== 1'b1) begin
            errors++; $display("FAIL ignored_ready got %b%b%b exp 001", got_rdy[11], got_rdy[63], got_rdy[64]);
        end
        for (int i = 0; i < 20; i++) begin
            if (active !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL ignored_no_frame got %0d active cycles exp 0", bad); end
        $display("ignored: data=0f0 sent, 155 dropped");
    endtask

    task automatic test_parity();
        logic [9:0] words [4] = '{10'h000, 10'h3FF, 10'h001, 10'h003};
        bit         par   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        int d;
        for (int k = 0; k < 4; k++) begin
            strobe_word(words[k]);
            build_frame(1, words[k], 10'h000);
            capture(-1, '0);
            checks++; if (got_tx[152] !== !par[k] || got_tx[156] !== par[k]) begin
                errors++; $display("FAIL parity_%h got %b%b exp %b%b", words[k], got_tx[152], got_tx[156], !par[k], par[k]);
            end
            d = first_diff();
            checks++; if (d >= 0 || got_tx.size() != 184) begin
                errors++; $display("FAIL parity_wave_%h idx %0d len %0d exp len 184", words[k], d, got_tx.size());
            end
            $display("parity: data=%h parity_cell=%b%b", words[k], got_tx[152], got_tx[156]);
        end
    endtask

    task automatic test_reset_mid();
        int d;
        int bad = 0;
        strobe_word(10'h1B3);
        for (int n = 0; n < 114; n++) begin
            if (n == 80) begin strobe = 1'b1; data = 10'h2AA; end
            tick();
            if (n == 80) strobe = 1'b0;
        end
        reset = 1'b1; strobe = 1'b1; data = 10'h155;
        tick();
        reset = 1'b0; strobe = 1'b0;
        checks++; if (tx !== 1'b0 || active !== 1'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid got tx=%b a=%b r=%b exp 0 0 1", tx, active, ready);
        end
        for (int i = 0; i < 10; i++) begin
            if (active !== 1'b0 || ready !== 1'b1) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL reset_mid_discard got %0d bad cycles exp 0", bad); end
        strobe_word(10'h003);
        build_frame(1, 10'h003, 10'h000);
        capture(-1, '0);
        d = first_diff();
        checks++; if (d >= 0 || got_tx.size() != 184) begin
            errors++; $display("FAIL reset_mid_fresh idx %0d len %0d exp len 184", d, got_tx.size());
        end
        $display("reset_mid: aborted at data bit 5, fresh frame len=%0d", got_tx.size());
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_ignored();
        test_parity();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
